// File: rtl/spi_register_controller.sv
// rtl/spi_register_controller.sv - register read/write command sequencer in front of an SPI master
//
// Turns one register command into a two-beat MOSI frame ({~write, addr}, then
// wdata or 0) and collects the two MISO beats.
// The second MISO beat is the read data.
// At most one command is in flight.
//
// Optional feature macro: SPI_REG_CTRL_TIMEOUT_EN
//   When defined, each MISO wait is bounded by TIMEOUT_CYCLES.
//   A wait that expires ends the command with rsp_error=1.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/cmd_addr/cmd_wdata  command fields, latched on acceptance
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_error           response fields
//   mosi_tdata/tvalid/tready      byte stream to the SPI master
//   miso_tdata/tvalid/tready      byte stream from the SPI master
//   busy                          high whenever a command is in progress
module spi_register_controller #(
    parameter int TRANSFER_WIDTH = 8,
    parameter int ADDR_WIDTH     = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [TRANSFER_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [TRANSFER_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_error,
    output logic [TRANSFER_WIDTH-1:0] mosi_tdata,
    output logic                      mosi_tvalid,
    input  logic                      mosi_tready,
    input  logic [TRANSFER_WIDTH-1:0] miso_tdata,
    input  logic                      miso_tvalid,
    output logic                      miso_tready,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_ADDR = 3'd1,
        WAIT_ADDR = 3'd2,
        SEND_DATA = 3'd3,
        WAIT_DATA = 3'd4,
        RESPOND   = 3'd5
    } state_t;

    state_t                    state;
    logic                      write_q;
    // Beat 1 is resolved at acceptance (wdata or zero), so SEND_DATA only copies it.
    logic [TRANSFER_WIDTH-1:0] beat1_q;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_WIDTH-1:0] timer;
    logic                   rsp_error_q;
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            mosi_tvalid <= 1'b0;
            mosi_tdata  <= '0;
            miso_tready <= 1'b0;
            busy        <= 1'b0;
            write_q     <= 1'b0;
            beat1_q     <= '0;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
            timer       <= '0;
            rsp_error_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Stray MISO beats are drained here by keeping miso_tready high.
                    cmd_ready   <= 1'b1;
                    miso_tready <= 1'b1;
                    if (cmd_ready && cmd_valid) begin
                        state       <= SEND_ADDR;
                        cmd_ready   <= 1'b0;
                        miso_tready <= 1'b0;
                        busy        <= 1'b1;
                        mosi_tvalid <= 1'b1;
                        mosi_tdata  <= {~cmd_write, cmd_addr};
                        write_q     <= cmd_write;
                        beat1_q     <= cmd_write ? cmd_wdata : '0;
                    end
                end
                SEND_ADDR: begin
                    if (mosi_tready) begin
                        state       <= WAIT_ADDR;
                        mosi_tvalid <= 1'b0;
                        miso_tready <= 1'b1;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
                        timer       <= '0;
`endif
                    end
                end
                WAIT_ADDR: begin
                    // The response to the address beat carries no information.
                    if (miso_tvalid) begin
                        state       <= SEND_DATA;
                        miso_tready <= 1'b0;
                        mosi_tvalid <= 1'b1;
                        mosi_tdata  <= beat1_q;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
                    end else if (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        state       <= RESPOND;
                        miso_tready <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_error_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
`endif
                    end
                end
                SEND_DATA: begin
                    if (mosi_tready) begin
                        state       <= WAIT_DATA;
                        mosi_tvalid <= 1'b0;
                        miso_tready <= 1'b1;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
                        timer       <= '0;
`endif
                    end
                end
                WAIT_DATA: begin
                    if (miso_tvalid) begin
                        state       <= RESPOND;
                        miso_tready <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= write_q ? '0 : miso_tdata;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
                    end else if (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        state       <= RESPOND;
                        miso_tready <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_error_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
`endif
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid   <= 1'b0;
                        cmd_ready   <= 1'b1;
                        miso_tready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready   <= 1'b0;
                    rsp_valid   <= 1'b0;
                    mosi_tvalid <= 1'b0;
                    miso_tready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_register_controller.sv
// tb/tb_spi_register_controller.sv - self-checking bench for spi_register_controller
module tb_spi_register_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic [7:0] mosi_tdata;
    logic       mosi_tvalid;
    logic       mosi_tready;
    logic [7:0] miso_tdata;
    logic       miso_tvalid;
    logic       miso_tready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // SPI master model: every accepted MOSI beat yields one MISO beat taken from miso_src.
    logic [7:0] mosi_log[$];
    logic [7:0] miso_src[$];
    logic [7:0] miso_q[$];
    int         stall = 0;
    bit         hold_second = 1'b0;
    bit         miso_mute = 1'b0;
    bit         stray_req = 1'b0;
    logic [7:0] stray_byte = 8'h00;
    bit         m_mosi_fire, m_miso_fire, m_stalled;
    logic [7:0] m_beat, m_stalled_data;

    spi_register_controller #(
        .TRANSFER_WIDTH(8),
        .ADDR_WIDTH(7),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .mosi_tdata(mosi_tdata),
        .mosi_tvalid(mosi_tvalid),
        .mosi_tready(mosi_tready),
        .miso_tdata(miso_tdata),
        .miso_tvalid(miso_tvalid),
        .miso_tready(miso_tready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        m_stalled = 1'b0;
        m_stalled_data = '0;
        mosi_tready = 1'b0;
        miso_tvalid = 1'b0;
        miso_tdata = '0;
        forever begin
            @(negedge clk);
            m_mosi_fire = mosi_tvalid && mosi_tready && !reset;
            m_miso_fire = miso_tvalid && miso_tready && !reset;
            m_beat = mosi_tdata;
            if (m_stalled && !reset) begin
                check("mosi_hold_valid", 32'(mosi_tvalid), 32'd1);
                check("mosi_hold_data", 32'(mosi_tdata), 32'(m_stalled_data));
            end
            m_stalled = mosi_tvalid && !mosi_tready && !reset;
            m_stalled_data = mosi_tdata;
            @(posedge clk);
            #1;
            if (reset) begin
                miso_q.delete();
                m_stalled = 1'b0;
            end else begin
                if (m_miso_fire) void'(miso_q.pop_front());
                if (m_mosi_fire) begin
                    mosi_log.push_back(m_beat);
                    if (!miso_mute)
                        miso_q.push_back(miso_src.size() != 0 ? miso_src.pop_front() : 8'($urandom));
                end
                if (stray_req) begin
                    miso_q.push_back(stray_byte);
                    stray_req = 1'b0;
                end
            end
            miso_tvalid = miso_q.size() != 0;
            miso_tdata = (miso_q.size() != 0) ? miso_q[0] : 8'h00;
            if (stall > 0) begin
                mosi_tready = 1'b0;
                stall--;
            end else begin
                mosi_tready = !(hold_second && mosi_log.size() >= 1);
            end
        end
    end

    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d, output bit ok);
        int n;
        @(posedge clk);
        #2;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!cmd_ready) begin
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        // Scramble the command inputs: the DUT must use the latched copy.
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr = 7'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic do_cmd(input logic w, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input int stall_n, input int hold);
        logic [7:0] exp_b0, exp_b1, exp_rd;
        int lat;
        bit ok;
        exp_b0 = {~w, a};
        exp_b1 = w ? d : 8'h00;
        exp_rd = w ? 8'h00 : b1;
        mosi_log.delete();
        miso_src.delete();
        miso_src.push_back(b0);
        miso_src.push_back(b1);
        rsp_ready = (hold == 0);
        stall = stall_n;
        issue(w, a, d, ok);
        if (!ok) return;
        lat = 1;
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("mosi_valid_after_accept", 32'(mosi_tvalid), 32'd1);
        while (!rsp_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        if (stall_n == 0 && hold == 0) check("latency", 32'(lat), 32'd5);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                check("rsp_hold_rdata", 32'(rsp_rdata), 32'(exp_rd));
                check("cmd_ready_while_rsp", 32'(cmd_ready), 32'd0);
            end
            @(posedge clk);
            #2;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("rsp_error", 32'(rsp_error), 32'd0);
        @(negedge clk);
        check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        check("mosi_beats", 32'(mosi_log.size()), 32'd2);
        if (mosi_log.size() == 2) begin
            check("mosi_beat0", 32'(mosi_log[0]), 32'(exp_b0));
            check("mosi_beat1", 32'(mosi_log[1]), 32'(exp_b1));
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        miso_src.delete();
        mosi_log.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit ok;
        bit seen;
        int n;
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        check("reset_mosi_tvalid", 32'(mosi_tvalid), 32'd0);
        check("reset_mosi_tdata", 32'(mosi_tdata), 32'd0);
        check("reset_miso_tready", 32'(miso_tready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("cmd_ready_after_edge", 32'(cmd_ready), 32'd1);

        // Directed cases.
        do_cmd(1'b1, 7'h15, 8'hA5, 8'hFF, 8'hFF, 0, 0);
        do_cmd(1'b0, 7'h15, 8'h00, 8'hFF, 8'h3C, 0, 0);
        do_cmd(1'b0, 7'h2B, 8'h00, 8'h11, 8'hC7, 10, 7);

        // Stray MISO beat in IDLE must be drained and not taken as read data.
        @(posedge clk);
        #2;
        stray_byte = 8'h77;
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_drained", 32'(miso_q.size()), 32'd0);
        do_cmd(1'b0, 7'h40, 8'h00, 8'h77, 8'h12, 0, 0);

        // Randomized commands.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
                stray_byte = 8'($urandom);
                stray_req = 1'b1;
                repeat (3) @(negedge clk);
            end
            do_cmd(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // No MISO reply after beat 0.
        miso_mute = 1'b1;
        mosi_log.delete();
        rsp_ready = 1'b1;
        issue(1'b0, 7'h0F, 8'h00, ok);
`ifdef SPI_REG_CTRL_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
        check("timeout_rsp_error", 32'(rsp_error), 32'd1);
        check("timeout_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("timeout_no_beat1", 32'(mosi_log.size()), 32'd1);
        @(negedge clk);
        check("timeout_idle", 32'(busy), 32'd0);
        miso_mute = 1'b0;
`else
        seen = 1'b0;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!busy || rsp_valid) seen = 1'b1;
        end
        check("stuck_busy_1000", 32'(seen), 32'd0);
        check("stuck_no_beat1", 32'(mosi_log.size()), 32'd1);
        miso_mute = 1'b0;
        pulse_reset();
`endif

        // Reset while in SEND_DATA.
        mosi_log.delete();
        miso_src.delete();
        miso_src.push_back(8'h5A);
        miso_src.push_back(8'h6B);
        hold_second = 1'b1;
        issue(1'b0, 7'h22, 8'h00, ok);
        n = 0;
        @(negedge clk);
        while (!(mosi_tvalid && mosi_log.size() == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_send_data", 32'(n < 100), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_mosi_tvalid", 32'(mosi_tvalid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_cmd_ready", 32'(cmd_ready), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        hold_second = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        miso_src.delete();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);
        do_cmd(1'b1, 7'h01, 8'h02, 8'h00, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/spi_register_controller.md
# spi_register_controller

Command sequencer directly upstream of the SPI master. Converts single-register read/write commands into a two-beat byte frame on the master's MOSI AXI stream and collects the two returned MISO bytes. For reads it returns the second MISO byte as read data. It decouples register-level clients from byte-level SPI traffic and serialises at most one command in flight.

## Interface
Parameters:
- `TRANSFER_WIDTH`, 8: SPI beat width in bits; frame byte width.
- `ADDR_WIDTH`, 7: register address width; must equal `TRANSFER_WIDTH-1`.
- `TIMEOUT_CYCLES`, 4096: maximum `clk` cycles spent waiting for a MISO beat (only with the timeout feature compiled in).

Ports:
- `clk` in 1: single clock for all logic; the SPI master streams share it.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: register address.
- `cmd_wdata` in TRANSFER_WIDTH: write data; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high with `rsp_valid`.
- `rsp_rdata` out TRANSFER_WIDTH: read data; 0 for writes and on error.
- `rsp_error` out 1: response terminated by timeout.
- `mosi_tdata` out TRANSFER_WIDTH: byte to the SPI master.
- `mosi_tvalid` out 1; `mosi_tready` in 1: AXIS handshake to the master sink.
- `miso_tdata` in TRANSFER_WIDTH: byte from the SPI master.
- `miso_tvalid` in 1; `miso_tready` out 1: AXIS handshake from the master source.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame: beat 0 = `{~cmd_write, cmd_addr}`, so the MSB is 1 for reads. Beat 1 = `cmd_wdata` for writes, `8'h00` for reads.
- Command fields are latched on acceptance. Later changes on the `cmd_*` inputs have no effect.
- State machine:
  - IDLE: `cmd_ready=1`, `miso_tready=1`. Stray MISO beats are discarded. On `cmd_valid` go to SEND_ADDR.
  - SEND_ADDR: `mosi_tvalid=1` with beat 0. On `mosi_tready` go to WAIT_ADDR.
  - WAIT_ADDR: `miso_tready=1`. On `miso_tvalid` discard the byte and go to SEND_DATA.
  - SEND_DATA: `mosi_tvalid=1` with beat 1. On `mosi_tready` go to WAIT_DATA.
  - WAIT_DATA: `miso_tready=1`. On `miso_tvalid` capture `miso_tdata` into `rsp_rdata` for reads (0 for writes), set `rsp_error=0`, and go to RESPOND.
  - RESPOND: `rsp_valid=1`. On `rsp_ready` go to IDLE.
- `miso_tready=0` in SEND_* and RESPOND, so the master is back-pressured and no beat is lost.
- `mosi_tdata`/`mosi_tvalid` are stable while `mosi_tvalid && !mosi_tready`. `rsp_*` are stable while `rsp_valid && !rsp_ready`.
- Reset values, asserted asynchronously:
  - state IDLE.
  - `cmd_ready=0` during reset, rising to 1 on the first clock edge after reset release.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_error=0`, `mosi_tvalid=0`, `mosi_tdata=0`, `miso_tready=0`, `busy=0`.
- Reset mid-command drops the command and response with no completion. `mosi_tvalid` falls immediately.

## Timing
- All outputs are registered.
- Command accepted at edge N: `mosi_tvalid` is high after edge N, `busy` is high after edge N.
- Beat handshakes complete on the edge where valid and ready are both high. The next state's outputs are visible the following cycle.
- Minimum command-to-response latency is 5 cycles with zero-wait handshakes: accept, addr, addr rsp, data, data rsp → `rsp_valid`.
- After `rsp_ready` at edge M, `cmd_ready=1` from edge M. There is no back-to-back acceptance in RESPOND.

## Configuration
- `SPI_REG_CTRL_TIMEOUT_EN` defined:
  - A cycle counter, width `$clog2(TIMEOUT_CYCLES+1)`, clears on entering WAIT_ADDR or WAIT_DATA.
  - It increments each cycle without `miso_tvalid`.
  - On reaching `TIMEOUT_CYCLES` go to RESPOND with `rsp_error=1` and `rsp_rdata=0`, skipping any remaining beat.
  - A beat arriving on the same cycle as the limit wins: normal completion.
- `SPI_REG_CTRL_TIMEOUT_EN` undefined: no counter is present, WAIT states wait indefinitely, and `rsp_error` is constant 0.

## Test plan
- Write, addr 0x15, data 0xA5, zero-wait sinks: MOSI beats 0x15 then 0xA5; response `rsp_rdata=0x00`, `rsp_error=0`, `rsp_valid` 5 cycles after acceptance.
- Read, addr 0x15, MISO returns 0xFF then 0x3C: MOSI beats 0x95 then 0x00; `rsp_rdata=0x3C`.
- `mosi_tready` low for 10 cycles, and `rsp_ready` low for 7 cycles: beat and response data stay stable; `cmd_ready` stays 0 until the response is consumed.
- Stray MISO beat 0x77 in IDLE, then a read returning 0x12: the stray beat is dropped and `rsp_rdata=0x12`.
- With the macro and `TIMEOUT_CYCLES=16`, no MISO beat after beat 0: `rsp_error=1`, `rsp_rdata=0`, and no beat 1 is issued. Without the macro, `busy` stays 1 for 1000 cycles.
- `reset` pulsed while in SEND_DATA: `mosi_tvalid` and `busy` drop asynchronously and no response is produced; a following write of 0x01/0x02 completes normally.
